systolic_seq_ctrl: RTL

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_seq_ctrl_counter.sv | 28 ++
 rtl/systolic_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam logic SEL_WEIGHT = 1'b0;
  localparam logic SEL_ACT    = 1'b1;

endpackage

// File: rtl/systolic_seq_ctrl_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// The count wraps back to zero on an enabled cycle at terminal count, so
// each phase leaves its counter ready for the next tile.
module seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == last);

  // count register: clear wins over enable, wrap at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= tc ? '0 : count + W'(1);
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic-array tile: loads N weight rows, streams len
// activation beats, flushes the skew pipeline for 2N-2 cycles, then pulses
// done. Define SYSTOLIC_SEQ_PERF_EN to add busy/stall cycle counters.
//
// state  | meaning
// IDLE   | waiting for start with non-zero len
// LOAD   | accepting weight rows 0..N-1 (weight mux path)
// STREAM | accepting len activation beats (activation mux path)
// DRAIN  | free-running act_en for 2N-2 cycles to flush the skew
// DONE   | one-cycle completion pulse
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic                         mux_sel,
  output logic                         wload_en,
  output logic [((N>1)?$clog2(N):1)-1:0] wrow,
  output logic                         act_en,
  output logic                         busy,
  output logic                         done
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [31:0]                  busy_cycles,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int LEN_W     = $clog2(MAX_LEN+1);
  localparam int WROW_W    = (N > 1) ? $clog2(N) : 1;
  localparam int DRAIN_LEN = 2*N - 2;
  localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam int DRAIN_TC  = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;

  seq_state_t         state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic               start_acc;
  logic               wrow_en, beat_en, drain_en;
  logic               wrow_tc, beat_tc, drain_tc;
  logic [WROW_W-1:0]  wrow_cnt;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  seq_counter #(.W(WROW_W)) u_wrow_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (wrow_en),
    .last  (WROW_W'(N-1)),
    .count (wrow_cnt),
    .tc    (wrow_tc)
  );

  seq_counter #(.W(LEN_W)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (beat_en),
    .last  (len_q - LEN_W'(1)),
    .count (beat_cnt),
    .tc    (beat_tc)
  );

  seq_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (drain_en),
    .last  (DRAIN_W'(DRAIN_TC)),
    .count (drain_cnt),
    .tc    (drain_tc)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // tile length captured with an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      len_q <= '0;
    else if (start_acc)
      len_q <= len;
  end

  // next-state and output decode; src_ready depends on state only
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    src_ready = 1'b0;
    mux_sel   = SEL_WEIGHT;
    wload_en  = 1'b0;
    wrow      = '0;
    act_en    = 1'b0;
    done      = 1'b0;
    wrow_en   = 1'b0;
    beat_en   = 1'b0;
    drain_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          start_acc = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        src_ready = 1'b1;
        wload_en  = src_valid;
        wrow      = wrow_cnt;
        wrow_en   = src_valid;
        if (src_valid && wrow_tc)
          state_nxt = STREAM;
      end
      STREAM: begin
        src_ready = 1'b1;
        mux_sel   = SEL_ACT;
        act_en    = src_valid;
        beat_en   = src_valid;
        if (src_valid && beat_tc)
          state_nxt = (DRAIN_LEN > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        mux_sel  = SEL_ACT;
        act_en   = 1'b1;
        drain_en = 1'b1;
        if (drain_tc)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef SYSTOLIC_SEQ_PERF_EN
  // saturating performance counters, cleared by each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else if (start_acc) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && (busy_cycles != '1))
        busy_cycles <= busy_cycles + 32'd1;
      if (src_ready && !src_valid && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
